// File: rtl/uart_rx_ctrl_pkg.sv
// uart_rx_ctrl_pkg: shared types and constants for the UART receive controller.
// Frame geometry, state encoding and the active receiver config bundle.
package uart_rx_ctrl_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam int MIN_PRESCALE    = 4;
  localparam int START_BITS      = 1;
  localparam int STOP_BITS       = 1;
  localparam int BASE_FRAME_BITS = START_BITS + 8 + STOP_BITS;

  typedef struct packed {
    logic [5:0] prescale;
    logic       par_en;
    logic       par_typ;
  } rx_cfg_t;

  function automatic logic [3:0] frame_bits(input logic par_en);
    return 4'(BASE_FRAME_BITS) + {3'b000, par_en};
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_fifo.sv
// uart_rx_ctrl_fifo: small synchronous FIFO for received bytes.
// Registered head (no fall-through); a push into a full FIFO without pop drops.
module uart_rx_ctrl_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  empty,
  output logic                  full,
  output logic                  drop,
  output logic [DATA_WIDTH-1:0] head
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                   (wr_ptr[AW] != rd_ptr[AW]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign drop    = push & ~do_push;
  assign head    = mem[rd_ptr[AW-1:0]];

  // pointer update; extra MSB separates full from empty
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + ONE;
      if (do_pop)  rd_ptr <= rd_ptr + ONE;
    end
  end

  // storage write, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: config shadow, frame watchdog and byte buffer for the UART RX path.
// Optional err_cnt output built when UART_RX_ERR_CNT_EN is defined.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int DEF_PRESCALE = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  cfg_wr,
  input  logic [5:0]            cfg_prescale,
  input  logic                  cfg_par_en,
  input  logic                  cfg_par_typ,
  output logic                  cfg_pending,
  output logic                  cfg_err,
  output logic [5:0]            rx_prescale,
  output logic                  rx_par_en,
  output logic                  rx_par_typ,
  input  logic                  rx_data_valid,
  input  logic [DATA_WIDTH-1:0] rx_p_data,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  frm_err,
  output logic                  ovf,
  input  logic                  ovf_clr
`ifdef UART_RX_ERR_CNT_EN
  ,
  output logic [7:0]            err_cnt
`endif
);

  localparam rx_cfg_t DEF_CFG = '{6'(DEF_PRESCALE), 1'b0, 1'b0};

  logic    rx_q;
  logic    fall;
  rx_cfg_t shadow;
  rx_cfg_t act;
  logic    cfg_ok;
  logic    apply;

  state_t     state;
  state_t     state_nxt;
  logic [5:0] edge_cnt;
  logic [5:0] edge_nxt;
  logic [3:0] bit_idx;
  logic [3:0] bit_nxt;
  logic       frame_ok;
  logic       ok_nxt;
  logic       frm_err_nxt;
  logic       last_edge;
  logic       expiry;
  logic [3:0] nbits;

  logic fifo_empty;
  logic fifo_full;
  logic fifo_drop;

  assign fall        = rx_q & ~RX_IN;
  assign cfg_ok      = (cfg_prescale >= 6'(MIN_PRESCALE));
  assign apply       = (state == IDLE) & cfg_pending & ~fall;
  assign rx_prescale = act.prescale;
  assign rx_par_en   = act.par_en;
  assign rx_par_typ  = act.par_typ;

  assign nbits     = frame_bits(act.par_en);
  assign last_edge = (edge_cnt == act.prescale - 6'd1);
  assign expiry    = (state == ACTIVE) & last_edge &
                     (bit_idx == nbits - 4'd1);

  // line history for falling-edge detection
  always_ff @(posedge CLK) begin
    if (RST) rx_q <= 1'b1;
    else     rx_q <= RX_IN;
  end

  // config capture into shadow; applied only while idle
  always_ff @(posedge CLK) begin
    if (RST) begin
      shadow      <= DEF_CFG;
      act         <= DEF_CFG;
      cfg_pending <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      cfg_err <= cfg_wr & ~cfg_ok;
      if (apply) act <= shadow;
      if (cfg_wr & cfg_ok) begin
        shadow      <= '{cfg_prescale, cfg_par_en, cfg_par_typ};
        cfg_pending <= 1'b1;
      end else if (apply) begin
        cfg_pending <= 1'b0;
      end
    end
  end

  // state register
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // next state, frame timer and watchdog decision
  always_comb begin
    state_nxt   = state;
    edge_nxt    = edge_cnt;
    bit_nxt     = bit_idx;
    ok_nxt      = frame_ok;
    frm_err_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (fall) begin
          state_nxt = ACTIVE;
          edge_nxt  = '0;
          bit_nxt   = '0;
          ok_nxt    = 1'b0;
        end
      end
      ACTIVE: begin
        if (rx_data_valid) ok_nxt = 1'b1;
        if (expiry) begin
          frm_err_nxt = ~frame_ok & ~rx_data_valid;
          if (fall) begin
            edge_nxt = '0;
            bit_nxt  = '0;
            ok_nxt   = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end else if (last_edge) begin
          edge_nxt = '0;
          bit_nxt  = bit_idx + 4'd1;
        end else begin
          edge_nxt = edge_cnt + 6'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // timer registers and frame-error pulse
  always_ff @(posedge CLK) begin
    if (RST) begin
      edge_cnt <= '0;
      bit_idx  <= '0;
      frame_ok <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      edge_cnt <= edge_nxt;
      bit_idx  <= bit_nxt;
      frame_ok <= ok_nxt;
      frm_err  <= frm_err_nxt;
    end
  end

  uart_rx_ctrl_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (rx_data_valid),
    .push_data (rx_p_data),
    .pop       (m_ready),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .drop      (fifo_drop),
    .head      (m_data)
  );

  assign m_valid = ~fifo_empty;

  // sticky overflow; a new drop beats a clear
  always_ff @(posedge CLK) begin
    if (RST)                       ovf <= 1'b0;
    else if (fifo_drop & fifo_full) ovf <= 1'b1;
    else if (ovf_clr)              ovf <= 1'b0;
  end

`ifdef UART_RX_ERR_CNT_EN
  logic [1:0] err_inc;
  logic [8:0] err_sum;

  assign err_inc = {1'b0, frm_err_nxt} + {1'b0, fifo_drop};
  assign err_sum = {1'b0, err_cnt} + {7'b0, err_inc};

  // saturating error counter; an increment beats a clear
  always_ff @(posedge CLK) begin
    if (RST)                  err_cnt <= '0;
    else if (err_inc != 2'd0) err_cnt <= err_sum[8] ? 8'hFF : err_sum[7:0];
    else if (ovf_clr)         err_cnt <= '0;
  end
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: self-checking bench for uart_rx_ctrl.
// Config table, frame timing sequences and a byte scoreboard on the FIFO side.
module tb_uart_rx_ctrl;
  import uart_rx_ctrl_pkg::*;

  localparam int DEPTH = 4;

  logic       CLK;
  logic       RST;
  logic       RX_IN;
  logic       cfg_wr;
  logic [5:0] cfg_prescale;
  logic       cfg_par_en;
  logic       cfg_par_typ;
  logic       cfg_pending;
  logic       cfg_err;
  logic [5:0] rx_prescale;
  logic       rx_par_en;
  logic       rx_par_typ;
  logic       rx_data_valid;
  logic [7:0] rx_p_data;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;
  logic       frm_err;
  logic       ovf;
  logic       ovf_clr;
`ifdef UART_RX_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  int n_vec = 0;
  int n_bad = 0;
  int frm_cnt = 0;
  logic [7:0] exp_q [$];

  typedef struct packed {
    logic [5:0] ps;
    logic       pe;
    logic       pt;
    logic       e_err;
    logic [5:0] e_ps;
    logic       e_pe;
    logic       e_pt;
  } cfg_vec_t;

  cfg_vec_t tbl [5];

  uart_rx_ctrl #(
    .DATA_WIDTH   (8),
    .FIFO_DEPTH   (DEPTH),
    .DEF_PRESCALE (8)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .RX_IN         (RX_IN),
    .cfg_wr        (cfg_wr),
    .cfg_prescale  (cfg_prescale),
    .cfg_par_en    (cfg_par_en),
    .cfg_par_typ   (cfg_par_typ),
    .cfg_pending   (cfg_pending),
    .cfg_err       (cfg_err),
    .rx_prescale   (rx_prescale),
    .rx_par_en     (rx_par_en),
    .rx_par_typ    (rx_par_typ),
    .rx_data_valid (rx_data_valid),
    .rx_p_data     (rx_p_data),
    .m_valid       (m_valid),
    .m_data        (m_data),
    .m_ready       (m_ready),
    .frm_err       (frm_err),
    .ovf           (ovf),
    .ovf_clr       (ovf_clr)
`ifdef UART_RX_ERR_CNT_EN
    ,
    .err_cnt       (err_cnt)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  always @(negedge CLK) begin
    if (!RST && m_valid && m_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL pop_unexpected: got %0h want none", m_data);
      end else begin
        chk("pop_data", {24'b0, m_data}, {24'b0, exp_q.pop_front()});
      end
    end
  end

  always @(negedge CLK) begin
    if (frm_err) frm_cnt++;
  end

  task automatic frame(input logic [7:0] d, input int p, input bit pe,
                       input bit pt, input bit give_valid, input int cfg_at);
    int nb;
    int vc;
    int bp;
    logic pb;
    nb = 10 + int'(pe);
    vc = (nb - 1) * p + p / 2;
    pb = (^d) ^ pt;
    for (int c = 0; c < nb * p; c++) begin
      bp = c / p;
      if (bp == 0)            RX_IN = 1'b0;
      else if (bp <= 8)       RX_IN = d[bp-1];
      else if (pe && bp == 9) RX_IN = pb;
      else                    RX_IN = 1'b1;
      rx_data_valid = give_valid && (c == vc);
      rx_p_data = d;
      cfg_wr = (c == cfg_at);
      if (rx_data_valid) exp_q.push_back(d);
      tick();
      if (c == 0) chk("enter_active", dut.state, ACTIVE);
      if (c == cfg_at) chk("cfg_pending_mid", cfg_pending, 1);
      if (give_valid && c == vc) begin
        chk("m_valid_lat1", m_valid, 1);
        chk("m_data_head", m_data, exp_q[0]);
      end
      if (c == nb * p - 1) begin
        chk("expiry_active", dut.state, ACTIVE);
        chk("prescale_held", rx_prescale, p);
      end
    end
    rx_data_valid = 1'b0;
    cfg_wr = 1'b0;
  endtask

  task automatic glitch(input int win);
    int early;
    early = 0;
    RX_IN = 1'b0;
    tick();
    chk("glitch_active", dut.state, ACTIVE);
    RX_IN = 1'b1;
    for (int k = 2; k <= win; k++) begin
      tick();
      if (frm_err) early++;
    end
    chk("frm_err_early", early, 0);
    tick();
    chk("frm_err_at_window", frm_err, 1);
    tick();
    chk("frm_err_one_cycle", frm_err, 0);
  endtask

  task automatic drain(input int n);
    m_ready = 1'b1;
    repeat (n) tick();
    m_ready = 1'b0;
    chk("sb_empty", exp_q.size(), 0);
    chk("drained", m_valid, 0);
  endtask

  task automatic push_byte(input logic [7:0] d);
    bit drop;
    drop = (exp_q.size() >= DEPTH) && !m_ready;
    rx_data_valid = 1'b1;
    rx_p_data = d;
    if (!drop) exp_q.push_back(d);
    tick();
    rx_data_valid = 1'b0;
  endtask

  initial begin
    int fb;
    tbl[0] = '{6'd3,  1'b0, 1'b1, 1'b1, 6'd16, 1'b1, 1'b0};
    tbl[1] = '{6'd4,  1'b0, 1'b1, 1'b0, 6'd4,  1'b0, 1'b1};
    tbl[2] = '{6'd0,  1'b1, 1'b1, 1'b1, 6'd4,  1'b0, 1'b1};
    tbl[3] = '{6'd63, 1'b1, 1'b1, 1'b0, 6'd63, 1'b1, 1'b1};
    tbl[4] = '{6'd8,  1'b0, 1'b0, 1'b0, 6'd8,  1'b0, 1'b0};

    RST = 1'b1;
    RX_IN = 1'b1;
    cfg_wr = 1'b0;
    cfg_prescale = '0;
    cfg_par_en = 1'b0;
    cfg_par_typ = 1'b0;
    rx_data_valid = 1'b0;
    rx_p_data = '0;
    m_ready = 1'b0;
    ovf_clr = 1'b0;
    repeat (2) tick();
    chk("rst_prescale", rx_prescale, 8);
    chk("rst_par_en", rx_par_en, 0);
    chk("rst_par_typ", rx_par_typ, 0);
    chk("rst_pending", cfg_pending, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_frm_err", frm_err, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_state", dut.state, IDLE);
    RST = 1'b0;
    tick();

    // good frame at prescale 8
    fb = frm_cnt;
    frame(8'hA5, 8, 0, 0, 1, -1);
    RX_IN = 1'b1;
    tick();
    chk("idle_after_80", dut.state, IDLE);
    chk("no_frm_err_good", frm_cnt, fb);
    drain(2);

    // line glitch, window 80
    fb = frm_cnt;
    glitch(80);
    chk("frm_err_count", frm_cnt, fb + 1);
`ifdef UART_RX_ERR_CNT_EN
    chk("err_cnt_one", err_cnt, 1);
`endif

    // config written mid-frame applies after expiry
    cfg_prescale = 6'd16;
    cfg_par_en = 1'b1;
    cfg_par_typ = 1'b0;
    frame(8'h96, 8, 0, 0, 1, 20);
    RX_IN = 1'b1;
    tick();
    chk("pending_in_idle", cfg_pending, 1);
    chk("not_yet_applied", rx_prescale, 8);
    tick();
    chk("applied_prescale", rx_prescale, 16);
    chk("applied_par_en", rx_par_en, 1);
    chk("pending_cleared", cfg_pending, 0);
    drain(2);
    fb = frm_cnt;
    frame(8'h3C, 16, 1, 0, 1, -1);
    RX_IN = 1'b1;
    tick();
    chk("idle_after_176", dut.state, IDLE);
    chk("no_frm_err_par", frm_cnt, fb);
    drain(2);
    glitch(176);

    // config table applied in idle
    foreach (tbl[i]) begin
      cfg_prescale = tbl[i].ps;
      cfg_par_en = tbl[i].pe;
      cfg_par_typ = tbl[i].pt;
      cfg_wr = 1'b1;
      tick();
      cfg_wr = 1'b0;
      chk("tbl_cfg_err", cfg_err, tbl[i].e_err);
      chk("tbl_pending", cfg_pending, !tbl[i].e_err);
      tick();
      chk("tbl_prescale", rx_prescale, tbl[i].e_ps);
      chk("tbl_par_en", rx_par_en, tbl[i].e_pe);
      chk("tbl_par_typ", rx_par_typ, tbl[i].e_pt);
      chk("tbl_pending_done", cfg_pending, 0);
      chk("tbl_err_pulse", cfg_err, 0);
    end

    // back-to-back frames, second start in expiry cycle
    fb = frm_cnt;
    frame(8'h5A, 8, 0, 0, 1, -1);
    frame(8'hC3, 8, 0, 0, 1, -1);
    RX_IN = 1'b1;
    tick();
    chk("idle_after_b2b", dut.state, IDLE);
    chk("no_frm_err_b2b", frm_cnt, fb);
    chk("b2b_two_bytes", exp_q.size(), 2);
    drain(3);

    // overflow and drain order
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_byte(8'(8'h11 * (i + 1)));
    chk("ovf_not_yet", ovf, 0);
    chk("full_head", m_data, 8'h11);
    push_byte(8'h55);
    chk("ovf_set", ovf, 1);
    repeat (2) tick();
    chk("ovf_sticky", ovf, 1);
    drain(4);
    chk("ovf_after_drain", ovf, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_cleared", ovf, 0);

    // full with simultaneous push and pop: no drop
    for (int i = 0; i < 4; i++) push_byte(8'(8'hA1 + i));
    m_ready = 1'b1;
    push_byte(8'hA5);
    m_ready = 1'b0;
    chk("push_pop_no_ovf", ovf, 0);
    chk("push_pop_occ", exp_q.size(), 4);
    ovf_clr = 1'b1;
    push_byte(8'hB6);
    ovf_clr = 1'b0;
    chk("ovf_set_wins", ovf, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_cleared2", ovf, 0);
    drain(5);

    // reset in the middle of a frame
    cfg_prescale = 6'd12;
    cfg_par_en = 1'b0;
    cfg_par_typ = 1'b0;
    cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
    tick();
    chk("pre_rst_prescale", rx_prescale, 12);
    push_byte(8'h77);
    fb = frm_cnt;
    RX_IN = 1'b0;
    tick();
    RX_IN = 1'b1;
    repeat (10) tick();
    chk("mid_frame_active", dut.state, ACTIVE);
    RST = 1'b1;
    tick();
    exp_q.delete();
    chk("midrst_state", dut.state, IDLE);
    chk("midrst_m_valid", m_valid, 0);
    chk("midrst_prescale", rx_prescale, 8);
    chk("midrst_pending", cfg_pending, 0);
    RST = 1'b0;
    repeat (200) tick();
    chk("midrst_no_frm_err", frm_cnt, fb);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
